ripple_count_sampler: RTL

- Reader side of the asynchronous ripple up/down counter: takes the counter's raw count bus (changes asynchronously to Clk, with ripple transients) into the Clk domain.
- Synchronizes each bit, rejects ripple intermediates with a stability filter, and publishes only settled count values.
- Per accepted value: reports count direction, wrap-around, and illegal multi-step jumps.
- Sits between any ripple counter instance and synchronous logic that consumes its count.

---
 rtl/ripple_count_sampler.sv | 99 +++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// Brings an asynchronous ripple counter's count bus into the Clk domain and
// publishes only settled values, flagging direction, wrap-around and illegal jumps.
module ripple_count_sampler #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             en,
  input  logic             err_clr,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] count_out,
  output logic             valid,
  output logic             dir,
  output logic             wrap,
  output logic             step_err
);

  // state | meaning
  // INIT  | waiting for a settled value to prime count_out; no pulses
  // TRACK | accepting settled changes, reporting dir / wrap / step_err
  typedef enum logic {INIT, TRACK} state_t;

  localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCW-1:0]   STAB_MAX = SCW'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAXV     = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand;
  logic [SCW-1:0]   stab_cnt;
  logic             stable;
  logic [WIDTH-1:0] delta;
  state_t           state;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], count_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any disagreement restarts the stability run on the new value
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      cand     <= '0;
      stab_cnt <= '0;
    end else if (s != cand) begin
      cand     <= s;
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign stable = (s == cand) && (stab_cnt == STAB_MAX);
  assign delta  = cand - count_out;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      count_out <= '0;
      valid     <= 1'b0;
      dir       <= 1'b1;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
      if (err_clr) step_err <= 1'b0;
      case (state)
        INIT: begin
          if (en && stable) begin
            count_out <= cand;
            state     <= TRACK;
          end
        end
        TRACK: begin
          if (!en) begin
            state <= INIT;
          end else if (stable && (cand != count_out)) begin
            count_out <= cand;
            valid     <= 1'b1;
            // assigned after the clear so a simultaneous error wins
            if (delta == ONE)       dir      <= 1'b1;
            else if (delta == MAXV) dir      <= 1'b0;
            else                    step_err <= 1'b1;
            wrap <= ((count_out == MAXV) && (cand == '0)) ||
                    ((count_out == '0) && (cand == MAXV));
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
